// File: rtl/tpg_pkg.sv
// Shared types for the test-pattern generator: the pattern-mode enum and the colour-bar table.
package tpg_pkg;

    typedef enum logic [1:0] {
        TPG_RAMP    = 2'd0,
        TPG_BARS    = 2'd1,
        TPG_CHECKER = 2'd2,
        TPG_SOLID   = 2'd3
    } tpg_mode_e;

    // {R,G,B} enables; entry 0 is the leftmost bar (white) and entry 7 is black
    localparam logic [7:0][2:0] BAR_TBL = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_en(input logic [2:0] idx);
        return BAR_TBL[idx];
    endfunction

endpackage

// File: rtl/tpg_timing.sv
// Raster counters, frame counter and frame-start configuration latch, plus the combinational
// hs/vs/de/sof decode and active-area coordinates. Exposes edge_c when TPG_BORDER_EN is defined.
module tpg_timing
    import tpg_pkg::*;
#(
    parameter int H_BITS  = 12,
    parameter int V_BITS  = 12,
    parameter int FC_BITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [H_BITS-1:0]  tHS_START,
    input  logic [H_BITS-1:0]  tHS_END,
    input  logic [H_BITS-1:0]  tHACT_START,
    input  logic [H_BITS-1:0]  tHACT_END,
    input  logic [H_BITS-1:0]  tH_END,
    input  logic [V_BITS-1:0]  tVS_START,
    input  logic [V_BITS-1:0]  tVS_END,
    input  logic [V_BITS-1:0]  tVACT_START,
    input  logic [V_BITS-1:0]  tVACT_END,
    input  logic [V_BITS-1:0]  tV_END,
    output tpg_mode_e          mode_eff,
    output logic [H_BITS-1:0]  xa,
    output logic [V_BITS-1:0]  ya,
    output logic               hs_c,
    output logic               vs_c,
    output logic               de_c,
    output logic               sof_c,
    output logic [FC_BITS-1:0] frame_cnt
`ifdef TPG_BORDER_EN
   ,output logic               edge_c
`endif
);

    typedef struct packed {
        logic [1:0]        mode;
        logic [H_BITS-1:0] hs_s, hs_e, ha_s, ha_e, h_end;
        logic [V_BITS-1:0] vs_s, vs_e, va_s, va_e, v_end;
    } cfg_t;

    logic [H_BITS-1:0]  x_q, x_d;
    logic [V_BITS-1:0]  y_q, y_d;
    logic [FC_BITS-1:0] fc_q, fc_d;
    cfg_t               cfg_q, cfg_d, cfg_live, cfg;
    logic               origin;

    assign cfg_live = {mode, tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END,
                       tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END};
    assign origin   = (x_q == '0) && (y_q == '0);

    // The origin pixel already runs on the values being captured, so a frame is self-consistent
    assign cfg = origin ? cfg_live : cfg_q;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        fc_d  = fc_q;
        cfg_d = cfg_q;
        if (en) begin
            if (origin) cfg_d = cfg_live;
            if (x_q == cfg.h_end) begin
                x_d = '0;
                if (y_q == cfg.v_end) begin
                    y_d  = '0;
                    fc_d = fc_q + FC_BITS'(1);
                end else begin
                    y_d = y_q + V_BITS'(1);
                end
            end else begin
                x_d = x_q + H_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            fc_q  <= '0;
            cfg_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            fc_q  <= fc_d;
            cfg_q <= cfg_d;
        end
    end

    always_comb begin
        hs_c  = (x_q >= cfg.hs_s) && (x_q < cfg.hs_e);
        vs_c  = (y_q >= cfg.vs_s) && (y_q < cfg.vs_e);
        de_c  = (x_q >= cfg.ha_s) && (x_q < cfg.ha_e) &&
                (y_q >= cfg.va_s) && (y_q < cfg.va_e);
        sof_c = de_c && (x_q == cfg.ha_s) && (y_q == cfg.va_s);
        xa    = x_q - cfg.ha_s;
        ya    = y_q - cfg.va_s;
    end

`ifdef TPG_BORDER_EN
    assign edge_c = (xa == '0) || (x_q == cfg.ha_e - H_BITS'(1)) ||
                    (ya == '0) || (y_q == cfg.va_e - V_BITS'(1));
`endif

    assign mode_eff  = tpg_mode_e'(cfg.mode);
    assign frame_cnt = fc_q;

endmodule

// File: rtl/tpg_gen.sv
// Video timing and test-pattern generator top: pattern mux and registered outputs.
// Optional macro TPG_BORDER_EN draws a one-pixel white border around the active area in modes 0-2.
module tpg_gen
    import tpg_pkg::*;
#(
    parameter int PW        = 8,
    parameter int H_BITS    = 12,
    parameter int V_BITS    = 12,
    parameter int BAR_SHIFT = 4,
    parameter int CHK_SHIFT = 3,
    parameter int FC_BITS   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [3*PW-1:0]    solid_rgb,
    input  logic [H_BITS-1:0]  tHS_START,
    input  logic [H_BITS-1:0]  tHS_END,
    input  logic [H_BITS-1:0]  tHACT_START,
    input  logic [H_BITS-1:0]  tHACT_END,
    input  logic [H_BITS-1:0]  tH_END,
    input  logic [V_BITS-1:0]  tVS_START,
    input  logic [V_BITS-1:0]  tVS_END,
    input  logic [V_BITS-1:0]  tVACT_START,
    input  logic [V_BITS-1:0]  tVACT_END,
    input  logic [V_BITS-1:0]  tV_END,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [3*PW-1:0]    rgb,
    output logic               sof,
    output logic [FC_BITS-1:0] frame_cnt
);

    localparam logic [H_BITS-1:0] BAR_MAX = H_BITS'(7);

    tpg_mode_e          mode_eff;
    logic [H_BITS-1:0]  xa, bar_full;
    logic [V_BITS-1:0]  ya;
    logic               hs_c, vs_c, de_c, sof_c;
    logic [PW-1:0]      ramp_v;
    logic [2:0]         bar_idx, bar_rgb;
    logic [3*PW-1:0]    pix;
    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d;
    logic [3*PW-1:0]    rgb_q, rgb_d;
`ifdef TPG_BORDER_EN
    logic               edge_c;
`endif

    tpg_timing #(
        .H_BITS  (H_BITS),
        .V_BITS  (V_BITS),
        .FC_BITS (FC_BITS)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .tHS_START   (tHS_START),
        .tHS_END     (tHS_END),
        .tHACT_START (tHACT_START),
        .tHACT_END   (tHACT_END),
        .tH_END      (tH_END),
        .tVS_START   (tVS_START),
        .tVS_END     (tVS_END),
        .tVACT_START (tVACT_START),
        .tVACT_END   (tVACT_END),
        .tV_END      (tV_END),
        .mode_eff    (mode_eff),
        .xa          (xa),
        .ya          (ya),
        .hs_c        (hs_c),
        .vs_c        (vs_c),
        .de_c        (de_c),
        .sof_c       (sof_c),
        .frame_cnt   (frame_cnt)
`ifdef TPG_BORDER_EN
       ,.edge_c      (edge_c)
`endif
    );

    always_comb begin
        ramp_v   = PW'(xa) + PW'(ya) + PW'(frame_cnt);
        bar_full = xa >> BAR_SHIFT;
        bar_idx  = (bar_full > BAR_MAX) ? 3'd7 : bar_full[2:0];
        bar_rgb  = bar_en(bar_idx);
        case (mode_eff)
            TPG_RAMP:    pix = {ramp_v, ramp_v, ramp_v};
            TPG_BARS:    pix = {{PW{bar_rgb[2]}}, {PW{bar_rgb[1]}}, {PW{bar_rgb[0]}}};
            TPG_CHECKER: pix = {(3*PW){xa[CHK_SHIFT] ^ ya[CHK_SHIFT]}};
            default:     pix = solid_rgb;
        endcase
`ifdef TPG_BORDER_EN
        if (edge_c && (mode_eff != TPG_SOLID)) pix = '1;
`endif
        if (!de_c) pix = '0;
    end

    // Output stage freezes with the counters when en is low
    always_comb begin
        hs_d  = hs_q;
        vs_d  = vs_q;
        de_d  = de_q;
        sof_d = sof_q;
        rgb_d = rgb_q;
        if (en) begin
            hs_d  = hs_c;
            vs_d  = vs_c;
            de_d  = de_c;
            sof_d = sof_c;
            rgb_d = pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
            sof_q <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            sof_q <= sof_d;
            rgb_q <= rgb_d;
        end
    end

    assign hs  = hs_q;
    assign vs  = vs_q;
    assign de  = de_q;
    assign sof = sof_q;
    assign rgb = rgb_q;

endmodule

// File: tb/tb_tpg_gen.sv
// Directed bench for tpg_gen: 16x10 raster, bars/ramp/checker/solid, en stall, frame latching, reset.
module tb_tpg_gen;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic        hs, vs, de, sof;
    logic [23:0] rgb;
    logic [15:0] frame_cnt;

    int n_chk = 0;
    int n_err = 0;
    int ncyc  = 0;
    int hs_n, de_n, sof_n;
    logic [23:0] line_rgb [16];

`ifdef TPG_BORDER_EN
    localparam logic [23:0] BRD = 24'hFFFFFF;
`else
    localparam logic [23:0] BRD = 24'h000000;
`endif

    always #5 clk = ~clk;

    tpg_gen #(.BAR_SHIFT(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
        .tHACT_END(tHACT_END), .tH_END(tH_END),
        .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
        .tVACT_END(tVACT_END), .tV_END(tV_END),
        .hs(hs), .vs(vs), .de(de), .rgb(rgb), .sof(sof), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance until outputs reflect raster position (fr, yy, xx) of the 16x10 frame
    task automatic goto(input int fr, input int yy, input int xx);
        int tgt;
        tgt = fr * 160 + yy * 16 + xx + 1;
        while (ncyc < tgt) begin
            @(posedge clk); #1;
            ncyc++;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; mode = 2'd1; solid_rgb = '0;
        tHS_START = 0; tHS_END = 2; tHACT_START = 4; tHACT_END = 12; tH_END = 15;
        tVS_START = 0; tVS_END = 1; tVACT_START = 2; tVACT_END = 8; tV_END = 9;
        #2 rst_n = 1'b0;
        #5;
        chk("rst_hs", hs, 0);
        chk("rst_vs", vs, 0);
        chk("rst_de", de, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_sof", sof, 0);
        chk("rst_fc", frame_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1;

        // frame 0: bars
        goto(0, 0, 0);
        chk("f0_origin_hs", hs, 1);
        chk("f0_origin_vs", vs, 1);
        chk("f0_origin_de", de, 0);
        goto(0, 0, 2);
        chk("hs_end_excl", hs, 0);
        goto(0, 1, 5);
        chk("vs_line1", vs, 0);
        hs_n = 0; de_n = 0; sof_n = 0;
        for (int xx = 0; xx < 16; xx++) begin
            goto(0, 2, xx);
            hs_n  += int'(hs);
            de_n  += int'(de);
            sof_n += int'(sof);
            line_rgb[xx] = rgb;
        end
        chk("hs_per_line", hs_n, 2);
        chk("de_per_line", de_n, 8);
        chk("sof_per_line", sof_n, 1);
        chk("bar_xa0", line_rgb[4], 24'hFFFFFF);
        chk("bar_xa1", line_rgb[5], 24'hFFFFFF);
        chk("bar_xa2", line_rgb[6], 24'hFFFF00);
        chk("bar_xa3", line_rgb[7], 24'hFFFF00);
        chk("bar_xa6", line_rgb[10], 24'h00FF00);
        chk("bar_de_off", line_rgb[12], 24'h000000);
        mode = 2'd0;
        goto(0, 3, 4);
        chk("mode_latched_f0", rgb, 24'hFFFFFF);
        goto(0, 7, 5);
        chk("de_last_line", de, 1);
        goto(0, 8, 5);
        chk("de_vend_excl", de, 0);

        // frame 1: ramp with en stall
        goto(1, 2, 4);
        chk("ramp_first", rgb, 24'h010101);
        chk("sof_f1", sof, 1);
        chk("fc_f1", frame_cnt, 1);
        goto(1, 3, 6);
        chk("ramp_pre_stall", rgb, 24'h040404);
        en = 1'b0;
        repeat (5) step();
        chk("stall_rgb", rgb, 24'h040404);
        chk("stall_de", de, 1);
        en = 1'b1;
        goto(1, 3, 7);
        chk("ramp_post_stall", rgb, 24'h050505);

        // frame 2: mode change mid-frame must not show until frame 3
        goto(2, 3, 6);
        mode = 2'd2;
        goto(2, 3, 7);
        chk("mode_held_f2", rgb, 24'h060606);
        goto(2, 9, 14);
        chk("fc_before_wrap", frame_cnt, 2);
        goto(2, 9, 15);
        chk("fc_480", frame_cnt, 3);

        // frame 3: checker (border build turns edges white)
        goto(3, 2, 4);
        chk("chk_xa0ya0", rgb, BRD);
        chk("sof_f3", sof, 1);
        goto(3, 3, 7);
        chk("chk_inner", rgb, 24'h000000);
        goto(3, 3, 11);
        chk("chk_x11", rgb, BRD);
        tHACT_END = 14;
        goto(3, 3, 12);
        chk("hact_latched_f3", de, 0);

        // frame 4: widened active area exposes checker bit 3
        goto(4, 3, 11);
        chk("chk_x11_f4", rgb, 24'h000000);
        goto(4, 3, 12);
        chk("de_x12_f4", de, 1);
        chk("chk_xa8", rgb, 24'hFFFFFF);
        mode = 2'd3;
        solid_rgb = 24'h123456;

        // frame 5: solid, sampled live
        goto(5, 3, 4);
        chk("solid_edge_px", rgb, 24'h123456);
        solid_rgb = 24'hABCDEF;
        goto(5, 3, 5);
        chk("solid_live", rgb, 24'hABCDEF);
        goto(5, 4, 7);
        chk("pre_rst_de", de, 1);

        // async reset mid-line, then tH_END=0 raster
        rst_n = 1'b0;
        #1;
        chk("arst_hs", hs, 0);
        chk("arst_vs", vs, 0);
        chk("arst_de", de, 0);
        chk("arst_rgb", rgb, 0);
        chk("arst_sof", sof, 0);
        chk("arst_fc", frame_cnt, 0);
        tH_END = 0;
        step();
        rst_n = 1'b1;
        step();
        chk("rel_hs", hs, 1);
        chk("rel_vs", vs, 1);
        chk("rel_de", de, 0);
        step();
        chk("h0_vs_y1", vs, 0);
        chk("h0_hs_y1", hs, 1);
        repeat (8) step();
        chk("h0_fc", frame_cnt, 1);
        step();
        chk("h0_vs_wrap", vs, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
